note_tone_gen: RTL and testbench
================================

// Module: note_tone_gen
// PURPOSE
//  Downstream of the auto-player note sequencer. Converts the 4-bit note code
//  (changes on quarter-beat edges, foreign domain) into a square-wave speaker drive
//  in the CLK domain. Synchronises and debounces the code, looks up the half-period
//  and toggles the output. Note changes and rests take effect only at half-period
//  boundaries, so the speaker never sees a runt pulse.
// PARAMETERS
//  CLK_HZ     100_000_000  system clock; table below is for this value
//  SIM_SHIFT  0            table half-periods >> SIM_SHIFT (simulation speed-up)
//  CNT_W      18           half-period counter width
// PORTS
//  CLK        in   1  system clock, rising edge
//  RESET      in   1  reset, asynchronous, active-high
//  note_in    in   4  note code: 0=none,1=C4,2=D,3=E,4=F,5=G,6=A,7=B,8=C5; 9-15=rest
//  mute       in   1  async switch; 1 forces rest
//  speaker    out  1  square-wave drive
//  note_active out 1  1 while in PLAY
//  cur_note   out  4  code currently sounding; 0 in REST
// BEHAVIOUR
//  Reset (async): speaker=0, note_active=0, cur_note=0, cnt=0, state=REST, sync regs=0.
//  Input sync: note_in -> s1 -> s2 (2 FF); mute -> m1 -> m2.
//   note_req <= s2 only when s2==s1 (stable 2 samples), else hold; mute_q <= m2 likewise.
//   Latency note_in change -> note_req: 3 CLK. 1-cycle glitches never reach note_req.
//  valid = (note_req in 1..8) && !mute_q.
//  Half-period LUT (CLK cycles, before >>SIM_SHIFT):
//   C4 191110, D 170266, E 151685, F 143172, G 127551, A 113636, B 101239, C5 95557.
//   Shift truncates. Shifted value <2 is clamped to 2.
//  half: CNT_W-bit register holding the shifted LUT value of cur_note.
//  FSM REST:
//   speaker=0, cnt=0, cur_note=0.
//   If valid: next cycle speaker=1, cur_note=note_req, half=LUT(note_req),
//   cnt=0, note_active=1, state=PLAY.
//   So speaker rises on the 4th CLK edge after note_in changes.
//  FSM PLAY:
//   cnt increments each CLK. Boundary = (cnt==half-1); at boundary cnt<=0.
//   Boundary and !valid: speaker<=0, cur_note<=0, note_active<=0, state=REST
//    (a high half always completes in full).
//   Boundary, valid, note_req!=cur_note: speaker toggles; cur_note/half load the new
//    note; the next half uses the new length.
//   Boundary, valid, same note: speaker toggles.
//   Off boundary: no change to speaker, cur_note or half, whatever note_req does.
//  Simultaneous events: RESET dominates all. note_req change and boundary in the same
//   cycle: the change applies at that boundary.
//  Output high/low time = exactly half CLK cycles (period 2*half).
//  No dead cycle between notes.
// TESTING
//  Reset: assert RESET mid-PLAY with speaker=1 -> speaker=0, note_active=0, cur_note=0
//   immediately, without waiting for a CLK edge.
//  Start: SIM_SHIFT=6, note_in 0->3 (E) -> speaker rises at edge 4, then toggles every
//   2370 CLK; cur_note=3.
//  Change: E playing, note_in->5 (G) 100 CLK into a high half -> high lasts 2370 total,
//   then halves of 1992; cur_note becomes 5 at that boundary.
//  Rest: note_in->0 mid-high -> speaker stays 1 to the boundary, then 0; note_active=0.
//   Code 12 or mute=1 gives the same result.
//  Glitch: note_in pulses 3->7->3 for 1 CLK -> no change to cur_note or to the
//   toggle timing.
//  Repeat: note_in 3->0->3 with a 10000-CLK gap -> speaker returns to REST, then
//   restarts with a fresh high half.

Source files
------------

// File: rtl/note_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : note_tone_gen
//  Purpose  : Turns the 4-bit note code from the auto-player sequencer (foreign
//             clock domain) into a square-wave speaker drive in the CLK domain.
//             The code and the mute switch are synchronised and filtered; the
//             half-period is looked up from a table, and the output toggles on
//             half-period boundaries. Note changes and rests only take effect
//             at a boundary, so the speaker never sees a runt pulse.
//  Ports    : CLK         in  1  system clock, rising edge
//             RESET       in  1  asynchronous, active-high reset
//             note_in     in  4  0=none, 1..8 = C4 D E F G A B C5, 9..15 = rest
//             mute        in  1  asynchronous switch, 1 forces rest
//             speaker     out 1  square-wave drive
//             note_active out 1  high while a note is playing
//             cur_note    out 4  code currently sounding, 0 when resting
//  Revision : 1.0  initial release
// ============================================================================
module note_tone_gen #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SIM_SHIFT = 0,
  parameter int CNT_W     = 18
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] note_in,
  input  logic       mute,
  output logic       speaker,
  output logic       note_active,
  output logic [3:0] cur_note
);

  typedef enum logic [0:0] {
    ST_REST = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  // Half-period in CLK cycles for a note code. The base table is for a
  // 100 MHz clock and is rescaled for other clock rates, then shifted down for
  // fast simulation. Very small results are clamped so the counter always has
  // a non-degenerate period.
  function automatic logic [CNT_W-1:0] half_lut(input logic [3:0] code);
    longint unsigned base;
    case (code)
      4'd1:    base = 64'd191110;
      4'd2:    base = 64'd170266;
      4'd3:    base = 64'd151685;
      4'd4:    base = 64'd143172;
      4'd5:    base = 64'd127551;
      4'd6:    base = 64'd113636;
      4'd7:    base = 64'd101239;
      4'd8:    base = 64'd95557;
      default: base = 64'd2;
    endcase
    base = (base * 64'(CLK_HZ)) / 64'd100_000_000;
    base = base >> SIM_SHIFT;
    if (base < 64'd2) begin
      base = 64'd2;
    end
    return base[CNT_W-1:0];
  endfunction

  // Synchroniser and stability filter registers.
  logic [3:0] s1_q, s2_q, note_req_q;
  logic       m1_q, m2_q, mute_q;

  // Tone generator registers.
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_q;
  logic             speaker_q;
  logic             active_q;
  logic [3:0]       cur_q;

  logic             w_valid;
  logic             w_boundary;
  logic [CNT_W-1:0] half_d;

  // Two-flop synchronisers. The filtered value only follows the second stage
  // when both stages agree, so a single-cycle glitch never gets through.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_q       <= 4'd0;
      s2_q       <= 4'd0;
      note_req_q <= 4'd0;
      m1_q       <= 1'b0;
      m2_q       <= 1'b0;
      mute_q     <= 1'b0;
    end else begin
      s1_q <= note_in;
      s2_q <= s1_q;
      m1_q <= mute;
      m2_q <= m1_q;
      if (s2_q == s1_q) begin
        note_req_q <= s2_q;
      end
      if (m2_q == m1_q) begin
        mute_q <= m2_q;
      end
    end
  end

  assign w_valid    = (note_req_q >= 4'd1) && (note_req_q <= 4'd8) && !mute_q;
  assign w_boundary = (cnt_q == (half_q - CNT_W'(1)));
  assign half_d     = half_lut(note_req_q);

  // Tone FSM. Every output change in PLAY is tied to a half-period boundary,
  // so a high half always runs its full length before a rest or a new note.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_REST;
      cnt_q     <= '0;
      half_q    <= CNT_W'(2);
      speaker_q <= 1'b0;
      active_q  <= 1'b0;
      cur_q     <= 4'd0;
    end else begin
      case (state_q)
        ST_REST: begin
          cnt_q     <= '0;
          speaker_q <= 1'b0;
          cur_q     <= 4'd0;
          active_q  <= 1'b0;
          if (w_valid) begin
            state_q   <= ST_PLAY;
            speaker_q <= 1'b1;
            cur_q     <= note_req_q;
            half_q    <= half_d;
            active_q  <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (w_boundary) begin
            cnt_q <= '0;
            if (!w_valid) begin
              state_q   <= ST_REST;
              speaker_q <= 1'b0;
              cur_q     <= 4'd0;
              active_q  <= 1'b0;
            end else begin
              // Reloading for the same note is harmless and keeps one path.
              speaker_q <= ~speaker_q;
              cur_q     <= note_req_q;
              half_q    <= half_d;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_REST;
        end
      endcase
    end
  end

  assign speaker     = speaker_q;
  assign note_active = active_q;
  assign cur_note    = cur_q;

endmodule
`default_nettype wire

// File: tb/tb_note_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_note_tone_gen
//  Purpose  : Self-checking bench for note_tone_gen. A reference model runs on
//             absolute cycle deadlines and queues every expected output change
//             with its edge number; a monitor pops and compares whenever the
//             DUT outputs change.
//  Revision : 1.0  initial release
// ============================================================================
module tb_note_tone_gen;

  localparam int SHIFT = 6;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] note_in = 4'd0;
  logic       mute = 1'b0;
  logic       speaker;
  logic       note_active;
  logic [3:0] cur_note;

  note_tone_gen #(
    .CLK_HZ   (100_000_000),
    .SIM_SHIFT(SHIFT),
    .CNT_W    (18)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .note_in    (note_in),
    .mute       (mute),
    .speaker    (speaker),
    .note_active(note_active),
    .cur_note   (cur_note)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         stamp;
    logic       spk;
    logic [3:0] cur;
    logic       act;
  } ev_t;

  ev_t exp_q[$];
  bit  chk_en = 1'b0;
  int  k = 0;

  // Reference model state
  logic [3:0] raw_h[$];
  bit         mraw_h[$];
  logic [3:0] m_req = 4'd0;
  bit         m_mute = 1'b0;
  bit         m_play = 1'b0;
  bit         m_spk = 1'b0;
  logic [3:0] m_cur = 4'd0;
  int         m_next = 0;
  logic [3:0] req_prev;
  bit         mute_prev, m_val, chg;
  ev_t        ev;

  function automatic int half_len(input logic [3:0] c);
    int t[8];
    int v;
    t = '{191110, 170266, 151685, 143172, 127551, 113636, 101239, 95557};
    v = t[int'(c) - 1] >> SHIFT;
    return (v < 2) ? 2 : v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  initial begin
    raw_h.push_back(4'd0);
    raw_h.push_back(4'd0);
    mraw_h.push_back(1'b0);
    mraw_h.push_back(1'b0);
  end

  // Reference model: sample history filter, then a player driven by
  // absolute boundary deadlines.
  always @(posedge CLK) begin
    if (chk_en) begin
      k++;
      req_prev  = m_req;
      mute_prev = m_mute;
      raw_h.push_back(note_in);
      mraw_h.push_back(mute);
      if (raw_h[$-1] == raw_h[$-2]) m_req = raw_h[$-1];
      if (mraw_h[$-1] == mraw_h[$-2]) m_mute = mraw_h[$-1];
      if (raw_h.size() > 3) void'(raw_h.pop_front());
      if (mraw_h.size() > 3) void'(mraw_h.pop_front());

      m_val = (req_prev >= 4'd1) && (req_prev <= 4'd8) && !mute_prev;
      chg = 1'b0;
      if (!m_play) begin
        if (m_val) begin
          m_play = 1'b1;
          m_spk  = 1'b1;
          m_cur  = req_prev;
          m_next = k + half_len(req_prev);
          chg    = 1'b1;
        end
      end else if (k == m_next) begin
        chg = 1'b1;
        if (!m_val) begin
          m_play = 1'b0;
          m_spk  = 1'b0;
          m_cur  = 4'd0;
        end else begin
          m_spk  = ~m_spk;
          m_cur  = req_prev;
          m_next = k + half_len(req_prev);
        end
      end
      if (chg) begin
        ev.stamp = k;
        ev.spk   = m_spk;
        ev.cur   = m_cur;
        ev.act   = m_play;
        exp_q.push_back(ev);
      end
    end
  end

  // Monitor: compares every DUT output change against the next queued event.
  logic       p_spk = 1'b0;
  logic [3:0] p_cur = 4'd0;
  logic       p_act = 1'b0;
  ev_t        got;

  always @(negedge CLK) begin
    if (chk_en) begin
      if (exp_q.size() != 0 && exp_q[0].stamp < k) begin
        tests++;
        fails++;
        $display("FAIL event_missing: expected change at edge %0d (spk=%b cur=%0d act=%b) not seen by edge %0d",
                 exp_q[0].stamp, exp_q[0].spk, exp_q[0].cur, exp_q[0].act, k);
        void'(exp_q.pop_front());
      end
      if ({speaker, cur_note, note_active} !== {p_spk, p_cur, p_act}) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL event_unexpected: edge %0d spk=%b cur=%0d act=%b, no change expected",
                   k, speaker, cur_note, note_active);
        end else begin
          got = exp_q.pop_front();
          if (got.stamp != k || got.spk !== speaker || got.cur !== cur_note || got.act !== note_active) begin
            fails++;
            $display("FAIL event: got edge %0d spk=%b cur=%0d act=%b, expected edge %0d spk=%b cur=%0d act=%b",
                     k, speaker, cur_note, note_active, got.stamp, got.spk, got.cur, got.act);
          end
        end
        p_spk = speaker;
        p_cur = cur_note;
        p_act = note_active;
      end
    end
  end

  task automatic hold(input logic [3:0] c, input int n);
    @(negedge CLK);
    note_in = c;
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic wait_rise();
    int  n;
    bit  seen_low;
    n = 0;
    seen_low = 1'b0;
    while (n < 8000) begin
      @(negedge CLK);
      n++;
      if (!speaker) seen_low = 1'b1;
      else if (seen_low) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_rise: speaker never rose within %0d cycles", n);
  endtask

  initial begin
    #1 RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_speaker", int'(speaker), 0);
    chk("reset_active", int'(note_active), 0);
    chk("reset_cur_note", int'(cur_note), 0);
    RESET  = 1'b0;
    chk_en = 1'b1;

    // Start on E, then change to G partway into a high half.
    hold(4'd3, 6000);
    wait_rise();
    repeat (99) @(negedge CLK);
    hold(4'd5, 5000);
    // Rest requested mid-high half.
    wait_rise();
    repeat (500) @(negedge CLK);
    hold(4'd0, 3000);
    // Out-of-range code behaves as rest.
    hold(4'd3, 3000);
    wait_rise();
    repeat (300) @(negedge CLK);
    hold(4'd12, 3000);
    // Mute behaves as rest.
    hold(4'd3, 3000);
    wait_rise();
    @(negedge CLK);
    mute = 1'b1;
    repeat (3000) @(negedge CLK);
    mute = 1'b0;
    // One-cycle glitch must not disturb playback.
    hold(4'd3, 3000);
    @(negedge CLK);
    note_in = 4'd7;
    @(negedge CLK);
    note_in = 4'd3;
    repeat (4000) @(negedge CLK);
    // Long gap, then restart with a fresh high half.
    hold(4'd0, 10000);
    hold(4'd3, 4000);

    // Randomised segments with occasional glitches and mute flips.
    for (int i = 0; i < 10; i++) begin
      hold(4'($urandom_range(0, 15)), $urandom_range(1, 2000));
      if ($urandom_range(0, 9) == 0) begin
        @(negedge CLK);
        note_in = 4'($urandom_range(0, 15));
        @(negedge CLK);
        note_in = 4'($urandom_range(1, 8));
      end
      if ($urandom_range(0, 9) == 0) begin
        @(negedge CLK);
        mute = ~mute;
      end
    end

    // Settle to rest and make sure every expected event was observed.
    @(negedge CLK);
    note_in = 4'd0;
    mute    = 1'b0;
    repeat (7000) @(negedge CLK);
    chk("events_left", exp_q.size(), 0);
    chk("settled_active", int'(note_active), int'(m_play));
    chk_en = 1'b0;

    // Asynchronous reset in the middle of a high half.
    @(negedge CLK);
    note_in = 4'd8;
    wait_rise();
    chk("pre_reset_speaker", int'(speaker), 1);
    #2 RESET = 1'b1;
    #1;
    chk("async_reset_speaker", int'(speaker), 0);
    chk("async_reset_active", int'(note_active), 0);
    chk("async_reset_cur_note", int'(cur_note), 0);
    note_in = 4'd0;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (6) @(negedge CLK);
    chk("post_reset_speaker", int'(speaker), 0);
    chk("post_reset_cur_note", int'(cur_note), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
